hazard_fwd_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline. It supersedes the single-purpose hazard detection unit by combining three functions in one block: load-use stall detection, EX-stage operand forwarding select, and taken-branch flush. It keeps its own shadow pipeline of register-use metadata (EX, MEM, WB), so the ID/EX, EX/MEM and MEM/WB registers need not export addresses back to it. It sits beside the ID stage and drives PC write enable, IF/ID write enable, the control-bubble mux select, the pipeline flush, and the two ALU-input forwarding muxes.

---
 rtl/pipe_pkg.sv | 36 +++
 rtl/hazard_fwd_ctrl_fwd_sel.sv | 20 ++
 rtl/hazard_fwd_ctrl.sv | 136 +++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Used by hazard_fwd_ctrl (optional stats via HAZARD_STATS_EN) and fwd_sel.
package pipe_pkg;

  // ALU operand source encodings
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // Shadow addresses are held at this width; narrower register files zero-extend.
  localparam int REG_AW_MAX = 8;
  typedef logic [REG_AW_MAX-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

  // Writer view of a pipeline slot (all that MEM and WB need)
  typedef struct packed {
    logic      v;
    reg_addr_t dst;
    logic      rw;
  } slot_t;

  // EX slot adds its source operands and the load flag
  typedef struct packed {
    slot_t     w;
    reg_addr_t rs;
    reg_addr_t rt;
    logic      mr;
  } ex_slot_t;

  // A slot produces a forwardable result only for a live, non-zero destination
  function automatic logic slot_writes(slot_t s);
    return s.v & s.rw & (s.dst != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel.sv
// fwd_sel: single-operand forwarding selector. MEM result beats WB result.
import pipe_pkg::*;

module fwd_sel (
  input  reg_addr_t   src,
  input  logic        mem_wr,
  input  reg_addr_t   mem_dst,
  input  logic        wb_wr,
  input  reg_addr_t   wb_dst,
  output logic [1:0]  sel
);

  // Youngest matching producer wins
  always_comb begin
    sel = FWD_REG;
    if (mem_wr && (mem_dst == src))     sel = FWD_MEM;
    else if (wb_wr && (wb_dst == src))  sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: load-use stall, EX operand forwarding and taken-branch flush
// for the 5-stage pipeline, tracked with a private EX/MEM/WB shadow pipeline.
// Define HAZARD_STATS_EN to build the stall/flush statistics counters.
import pipe_pkg::*;

module hazard_fwd_ctrl #(
  parameter int REG_AW = 5,   // must not exceed REG_AW_MAX
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic [REG_AW-1:0] id_dst_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              br_taken_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ctrl_bubble_o,
  output logic              flush_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  ex_slot_t  ex_q;
  slot_t     mem_q, wb_q;
  reg_addr_t id_rs, id_rt, id_dst;
  ex_slot_t  id_slot;
  logic      stall_raw, stall_eff;

  assign id_rs  = reg_addr_t'(id_rs_i);
  assign id_rt  = reg_addr_t'(id_rt_i);
  assign id_dst = reg_addr_t'(id_dst_i);

  // Instruction currently in ID, as it would enter EX
  always_comb begin
    id_slot      = '0;
    id_slot.w.v  = 1'b1;
    id_slot.w.dst = id_dst;
    id_slot.w.rw = id_regwrite_i;
    id_slot.rs   = id_rs;
    id_slot.rt   = id_rt;
    id_slot.mr   = id_memread_i;
  end

  // Load in EX whose result the ID instruction needs; a taken branch overrides it
  always_comb begin
    stall_raw = ex_q.w.v & ex_q.mr & (ex_q.w.dst != REG_ZERO) &
                ((id_use_rs_i & (id_rs == ex_q.w.dst)) |
                 (id_use_rt_i & (id_rt == ex_q.w.dst)));
    stall_eff = stall_raw & ~br_taken_i;
  end

  // Pipeline control; a frozen pipeline loads nothing and flushes nothing
  always_comb begin
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ctrl_bubble_o = 1'b0;
    flush_o       = 1'b0;
    if (start_i) begin
      pc_write_o    = ~stall_eff;
      ifid_write_o  = ~stall_eff;
      ctrl_bubble_o = stall_eff;
      flush_o       = br_taken_i;
    end
  end

  // Shadow pipeline: bubbles and squashed slots are fully cleared so they
  // can never match a later operand
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (start_i) begin
      if (br_taken_i || stall_eff) ex_q <= '0;
      else                         ex_q <= id_slot;
      if (br_taken_i) mem_q <= '0;
      else            mem_q <= ex_q.w;
      // The branch itself retires into WB but never writes
      wb_q.v   <= mem_q.v;
      wb_q.dst <= mem_q.dst;
      wb_q.rw  <= mem_q.rw & ~br_taken_i;
    end
  end

  logic mem_wr, wb_wr;
  assign mem_wr = slot_writes(mem_q);
  assign wb_wr  = slot_writes(wb_q);

  fwd_sel u_fwd_a (
    .src     (ex_q.rs),
    .mem_wr  (mem_wr),
    .mem_dst (mem_q.dst),
    .wb_wr   (wb_wr),
    .wb_dst  (wb_q.dst),
    .sel     (fwd_a_o)
  );

  fwd_sel u_fwd_b (
    .src     (ex_q.rt),
    .mem_wr  (mem_wr),
    .mem_dst (mem_q.dst),
    .wb_wr   (wb_wr),
    .wb_dst  (wb_q.dst),
    .sel     (fwd_b_o)
  );

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Count effective stalls and flushes on advancing cycles; wrap naturally
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (start_i) begin
      if (stall_eff)  stall_cnt_q <= stall_cnt_q + 1'b1;
      if (br_taken_i) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed vector table, reset/counter sequences,
// and random stimulus against an instruction-level pipeline model.
module tb_hazard_fwd_ctrl;

  localparam int AW = 5;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start, use_rs, use_rt, regwrite, memread, br;
  logic [AW-1:0] rs, rt, dst;
  logic pc_write, ifid_write, bubble, flush;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start),
    .id_rs_i(rs), .id_rt_i(rt), .id_use_rs_i(use_rs), .id_use_rt_i(use_rt),
    .id_dst_i(dst), .id_regwrite_i(regwrite), .id_memread_i(memread),
    .br_taken_i(br), .pc_write_o(pc_write), .ifid_write_o(ifid_write),
    .ctrl_bubble_o(bubble), .flush_o(flush), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  typedef struct {
    logic v;
    logic [4:0] rs, rt, dst;
    logic urs, urt, rw, mr;
  } ins_t;

  typedef struct {
    ins_t id;
    logic br, st;
    logic pc, ifid, bub, fl;
    logic [1:0] fa, fb;
  } vec_t;

  // Instruction-level model: which instruction sits in each later stage
  ins_t m_ex, m_mem, m_wb;
  ins_t nop_i;
  int m_stalls, m_flushes;

  function automatic ins_t mk(int a, int b, bit ua, bit ub, int d, bit w, bit m);
    ins_t i;
    i.v = 1'b1; i.rs = a[4:0]; i.rt = b[4:0]; i.urs = ua; i.urt = ub;
    i.dst = d[4:0]; i.rw = w; i.mr = m;
    return i;
  endfunction

  function automatic vec_t mkv(ins_t i, bit b, bit s, bit p, bit f, bit bb, bit fl,
                               logic [1:0] a, logic [1:0] c);
    vec_t t;
    t.id = i; t.br = b; t.st = s; t.pc = p; t.ifid = f; t.bub = bb; t.fl = fl;
    t.fa = a; t.fb = c;
    return t;
  endfunction

  function automatic bit produces(ins_t s, logic [4:0] r);
    return s.v && s.rw && (s.dst != 5'd0) && (s.dst == r);
  endfunction

  function automatic logic [1:0] m_fwd(logic [4:0] r);
    if (produces(m_mem, r)) return 2'b10;
    if (produces(m_wb, r))  return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_load_use(ins_t id);
    if (!(m_ex.v && m_ex.mr && m_ex.dst != 5'd0)) return 1'b0;
    return (id.urs && id.rs == m_ex.dst) || (id.urt && id.rt == m_ex.dst);
  endfunction

  task automatic model_reset();
    m_ex = nop_i; m_mem = nop_i; m_wb = nop_i;
    m_stalls = 0; m_flushes = 0;
  endtask

  task automatic model_step(ins_t id, bit b, bit s);
    bit hold;
    if (!s) return;
    hold = m_load_use(id) && !b;
    if (hold) m_stalls++;
    if (b) m_flushes++;
    if (b) begin
      m_wb = m_mem; m_wb.rw = 1'b0; m_mem = nop_i; m_ex = nop_i;
    end else if (hold) begin
      m_wb = m_mem; m_mem = m_ex; m_ex = nop_i;
    end else begin
      m_wb = m_mem; m_mem = m_ex; m_ex = id;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(ins_t i, bit b, bit s);
    rs = i.rs; rt = i.rt; use_rs = i.urs; use_rt = i.urt; dst = i.dst;
    regwrite = i.rw; memread = i.mr; br = b; start = s;
  endtask

  // Compare every output against the model for the currently driven inputs
  task automatic chk_model(string tag, ins_t id, bit b, bit s);
    bit hold;
    hold = m_load_use(id) && !b;
    chk({tag, ".pc"},    32'(pc_write),   32'(s && !hold));
    chk({tag, ".ifid"},  32'(ifid_write), 32'(s && !hold));
    chk({tag, ".bub"},   32'(bubble),     32'(s && hold));
    chk({tag, ".flush"}, 32'(flush),      32'(s && b));
    chk({tag, ".fa"},    32'(fwd_a),      32'(m_fwd(m_ex.rs)));
    chk({tag, ".fb"},    32'(fwd_b),      32'(m_fwd(m_ex.rt)));
`ifdef HAZARD_STATS_EN
    chk({tag, ".scnt"},  stall_cnt, 32'(m_stalls));
    chk({tag, ".fcnt"},  flush_cnt, 32'(m_flushes));
`else
    chk({tag, ".scnt"},  stall_cnt, 32'd0);
    chk({tag, ".fcnt"},  flush_cnt, 32'd0);
`endif
  endtask

  // One pipeline cycle: drive, check mid-cycle, clock, advance model
  task automatic step(string tag, ins_t id, bit b, bit s);
    drive(id, b, s);
    #2;
    chk_model(tag, id, b, s);
    @(posedge clk);
    model_step(id, b, s);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[17];
  ins_t ri;
  bit rb, rstart;

  initial begin
    nop_i = '{default: '0};
    model_reset();
    drive(nop_i, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk_model("reset", nop_i, 1'b0, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed program; expectations worked out by hand per instruction
    tbl[0]  = mkv(mk(1, 2, 1, 0, 2, 1, 1),    0, 1, 1, 1, 0, 0, 2'b00, 2'b00); // lw $2
    tbl[1]  = mkv(mk(2, 4, 1, 1, 3, 1, 0),    0, 1, 0, 0, 1, 0, 2'b00, 2'b00); // add $3,$2,$4 stalls
    tbl[2]  = mkv(mk(2, 4, 1, 1, 3, 1, 0),    0, 1, 1, 1, 0, 0, 2'b00, 2'b00); // single stall cycle
    tbl[3]  = mkv(mk(1, 1, 1, 1, 5, 1, 0),    0, 1, 1, 1, 0, 0, 2'b01, 2'b00); // add in EX takes WB load
    tbl[4]  = mkv(mk(5, 5, 1, 1, 6, 1, 0),    0, 1, 1, 1, 0, 0, 2'b00, 2'b00); // sub $6,$5,$5
    tbl[5]  = mkv(mk(5, 5, 1, 1, 8, 1, 0),    0, 1, 1, 1, 0, 0, 2'b10, 2'b10); // sub in EX: MEM fwd
    tbl[6]  = mkv(mk(1, 7, 1, 0, 7, 1, 0),    0, 1, 1, 1, 0, 0, 2'b01, 2'b01); // gap of one: WB fwd
    tbl[7]  = mkv(mk(1, 1, 1, 1, 7, 1, 0),    0, 1, 1, 1, 0, 0, 2'b00, 2'b00); // add $7
    tbl[8]  = mkv(mk(7, 0, 1, 1, 9, 1, 0),    0, 1, 1, 1, 0, 0, 2'b00, 2'b00); // reader of $7
    tbl[9]  = mkv(mk(1, 0, 1, 0, 0, 1, 1),    0, 1, 1, 1, 0, 0, 2'b10, 2'b00); // MEM beats WB on $7
    tbl[10] = mkv(mk(0, 0, 1, 1, 10, 1, 0),   0, 1, 1, 1, 0, 0, 2'b00, 2'b00); // lw $0: no stall
    tbl[11] = mkv(mk(0, 0, 1, 1, 11, 1, 0),   0, 1, 1, 1, 0, 0, 2'b00, 2'b00); // $0 never forwards
    tbl[12] = mkv(mk(1, 12, 1, 0, 12, 1, 1),  0, 1, 1, 1, 0, 0, 2'b00, 2'b00); // lw $12
    tbl[13] = mkv(mk(12, 12, 1, 1, 13, 1, 0), 1, 1, 1, 1, 0, 1, 2'b00, 2'b00); // branch beats stall
    tbl[14] = mkv(mk(11, 11, 1, 1, 14, 1, 0), 0, 1, 1, 1, 0, 0, 2'b00, 2'b00); // squashed slots silent
    tbl[15] = mkv(mk(14, 14, 1, 1, 15, 1, 0), 1, 0, 0, 0, 0, 0, 2'b00, 2'b00); // frozen: no flush
    tbl[16] = mkv(mk(14, 14, 1, 1, 15, 1, 0), 0, 1, 1, 1, 0, 0, 2'b00, 2'b00);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].id, tbl[i].br, tbl[i].st);
      #2;
      chk($sformatf("vec%0d.pc", i),    32'(pc_write),   32'(tbl[i].pc));
      chk($sformatf("vec%0d.ifid", i),  32'(ifid_write), 32'(tbl[i].ifid));
      chk($sformatf("vec%0d.bub", i),   32'(bubble),     32'(tbl[i].bub));
      chk($sformatf("vec%0d.flush", i), 32'(flush),      32'(tbl[i].fl));
      chk($sformatf("vec%0d.fa", i),    32'(fwd_a),      32'(tbl[i].fa));
      chk($sformatf("vec%0d.fb", i),    32'(fwd_b),      32'(tbl[i].fb));
      @(posedge clk);
      #1;
    end

    // Reset asserted in the middle of a load-use stall
    do_reset();
    step("rs_lw", mk(1, 2, 1, 0, 2, 1, 1), 1'b0, 1'b1);
    drive(mk(2, 2, 1, 1, 3, 1, 0), 1'b0, 1'b1);
    #2;
    chk("rs_pre.bub", 32'(bubble), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rs_async.pc",   32'(pc_write),   32'd1);
    chk("rs_async.ifid", 32'(ifid_write), 32'd1);
    chk("rs_async.bub",  32'(bubble),     32'd0);
    chk("rs_async.fa",   32'(fwd_a),      32'd0);
    br = 1'b1;
    #1;
    chk("rs_flush_in_reset", 32'(flush), 32'd1);
    start = 1'b0;
    #1;
    chk("rs_flush_frozen", 32'(flush), 32'd0);
    chk("rs_cnt", stall_cnt, 32'd0);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // Three load-use stalls, then the counter value
    for (int k = 0; k < 3; k++) begin
      step("cn_lw",  mk(1, 2, 1, 0, 2, 1, 1), 1'b0, 1'b1);
      step("cn_st",  mk(3, 2, 1, 1, 4, 1, 0), 1'b0, 1'b1);
      step("cn_go",  mk(3, 2, 1, 1, 4, 1, 0), 1'b0, 1'b1);
      step("cn_nop", nop_i, 1'b0, 1'b1);
    end
    #2;
`ifdef HAZARD_STATS_EN
    chk("cnt_three_stalls", stall_cnt, 32'd3);
`else
    chk("cnt_three_stalls", stall_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;

    // Random traffic over a small register set to provoke hazards
    do_reset();
    for (int n = 0; n < 400; n++) begin
      ri = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
              $urandom_range(0, 1));
      rb = ($urandom_range(0, 7) == 0);
      rstart = ($urandom_range(0, 7) != 0);
      step($sformatf("rnd%0d", n), ri, rb, rstart);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
